lr_normalizer_seq: RTL



---
 rtl/lr_shift_pkg.sv | 16 +
 rtl/lr_shift_step.sv | 28 ++
 rtl/lr_normalizer_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/lr_shift_pkg.sv
// Shared types for the left/right shifter family: shift direction and
// the normalizer's control states.
package lr_shift_pkg;

   typedef enum logic {
      ShiftDir_Left  = 1'b0,
      ShiftDir_Right = 1'b1
   } t_enum_ShiftDir;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } t_enum_NormState;

endpackage

// File: rtl/lr_shift_step.sv
// One-position left/right shift with zero fill, plus detection of the
// bit that will lead after normalization in the selected direction
// (MSB for Left, LSB for Right).
module lr_shift_step
   import lr_shift_pkg::*;
#(
   parameter int width = 8
) (
   input  logic [width-1:0] bits,
   input  t_enum_ShiftDir   dir,
   output logic [width-1:0] shifted,
   output logic             lead
);

   // Select shift direction and the matching lead bit.
   always_comb begin
      shifted = '0;
      lead    = 1'b0;
      if (dir == ShiftDir_Left) begin
         shifted = {bits[width-2:0], 1'b0};
         lead    = bits[width-1];
      end else begin
         shifted = {1'b0, bits[width-1:1]};
         lead    = bits[0];
      end
   end

endmodule

// File: rtl/lr_normalizer_seq.sv
// Iterative normalizer: shifts a captured vector one position per cycle
// until its lead bit is set (or it is all zeros), then presents the
// normalized vector and the shift count behind a valid/ready handshake.
module lr_normalizer_seq
   import lr_shift_pkg::*;
#(
   parameter int width = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [width-1:0]         iBits,
   input  t_enum_ShiftDir           dir,
   input  logic                     i_valid,
   output logic                     i_ready,
   output logic [width-1:0]         oBits,
   output logic [$clog2(width)-1:0] shift,
   output logic                     zero,
   output logic                     o_valid,
   input  logic                     o_ready
);

   localparam int SW = $clog2(width);

   t_enum_NormState state_reg, state_next;
   t_enum_ShiftDir  dir_reg, dir_next;
   logic [width-1:0] work_reg, work_next;
   logic [SW-1:0]    count_reg, count_next;
   logic [width-1:0] obits_reg, obits_next;
   logic [SW-1:0]    shift_reg, shift_next;
   logic             zero_reg, zero_next;

   logic [width-1:0] step_bits;
   logic             step_lead;

   lr_shift_step #(.width(width)) u_step (
      .bits    (work_reg),
      .dir     (dir_reg),
      .shifted (step_bits),
      .lead    (step_lead)
   );

   // Next-state and datapath updates; result registers load only on the
   // SHIFT->DONE transition so they stay frozen while DONE is back-pressured.
   always_comb begin
      state_next = state_reg;
      dir_next   = dir_reg;
      work_next  = work_reg;
      count_next = count_reg;
      obits_next = obits_reg;
      shift_next = shift_reg;
      zero_next  = zero_reg;
      case (state_reg)
         IDLE: begin
            if (i_valid) begin
               work_next  = iBits;
               dir_next   = dir;
               count_next = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (work_reg == '0 || step_lead) begin
               obits_next = work_reg;
               shift_next = count_reg;
               zero_next  = (work_reg == '0);
               state_next = DONE;
            end else begin
               work_next  = step_bits;
               count_next = count_reg + SW'(1);
            end
         end
         DONE: begin
            if (o_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         dir_reg   <= ShiftDir_Left;
         work_reg  <= '0;
         count_reg <= '0;
         obits_reg <= '0;
         shift_reg <= '0;
         zero_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         dir_reg   <= dir_next;
         work_reg  <= work_next;
         count_reg <= count_next;
         obits_reg <= obits_next;
         shift_reg <= shift_next;
         zero_reg  <= zero_next;
      end
   end

   assign i_ready = (state_reg == IDLE);
   assign o_valid = (state_reg == DONE);
   assign oBits   = obits_reg;
   assign shift   = shift_reg;
   assign zero    = zero_reg;

endmodule
